// File: rtl/instmem_boot.sv
// Instruction memory with a boot loader: copies a fixed boot image into the low
// words after reset, then serves registered fetches and byte-enabled writes.
module instmem_boot #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 256,
   parameter int BOOT_LEN = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     datain,
   input  logic [DATA_W/8-1:0]   be,
   input  logic                  rd_req,
   output logic [DATA_W-1:0]     dataout,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  err
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [2:0]      LAST_CNT  = 3'(BOOT_LEN - 1);

   typedef enum logic {BOOT, RUN} state_t;

   state_t           state, state_nx;
   logic [2:0]       cnt, cnt_nx;
   logic [DATA_W-1:0] mem [DEPTH];

   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] boot_idx;
   logic             rd_go, wr_go;

   function automatic logic [DATA_W-1:0] boot_word(input logic [2:0] i);
      logic [31:0] w;
      case (i)
         3'd0:    w = 32'h6040_0000;
         3'd1:    w = 32'h6040_0014;
         3'd2:    w = 32'h6080_0000;
         3'd3:    w = 32'h6080_001A;
         3'd4:    w = 32'h08C2_2000;
         default: w = 32'h0000_0000;
      endcase
      return DATA_W'(w);
   endfunction

   assign in_range = ({1'b0, addr} < DEPTH_EXT);
   assign idx      = addr[IDX_W-1:0];
   assign boot_idx = IDX_W'(cnt);
   assign busy     = (state == BOOT);
   assign rd_go    = (state == RUN) && rd_req;
   assign wr_go    = (state == RUN) && write;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
         cnt   <= 3'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == BOOT) begin
         cnt_nx = cnt + 3'd1;
         if (cnt == LAST_CNT) state_nx = RUN;
      end
   end

   // Contents survive reset; only the boot image region is rewritten.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == BOOT) begin
            mem[boot_idx] <= boot_word(cnt);
         end else if (wr_go && in_range) begin
            for (int i = 0; i < NB; i++)
               if (be[i]) mem[idx][8*i +: 8] <= datain[8*i +: 8];
         end
      end
   end

   // Nonblocking read of mem gives read-first behaviour on a same-address write.
   always_ff @(posedge clk) begin
      if (reset) begin
         dataout  <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_valid <= rd_go;
         err      <= (rd_go || wr_go) && !in_range;
         if (rd_go) dataout <= in_range ? mem[idx] : '0;
      end
   end

endmodule

// File: tb/tb_instmem_boot.sv
// Bench for instmem_boot: directed steps plus random traffic against a word-level
// model; a second instance covers a narrow, shallow, short-boot configuration.
module tb_instmem_boot;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // default configuration
   logic        rst, wr, rd;
   logic [15:0] ad;
   logic [31:0] di;
   logic [3:0]  be;
   logic [31:0] dout;
   logic        vld, busy, err;

   // DATA_W=16, DEPTH=64, BOOT_LEN=3
   logic        rst2, wr2, rd2;
   logic [15:0] ad2;
   logic [15:0] di2;
   logic [1:0]  be2;
   logic [15:0] dout2;
   logic        vld2, busy2, err2;

   instmem_boot dut (
      .clk(clk), .reset(rst), .write(wr), .addr(ad), .datain(di), .be(be),
      .rd_req(rd), .dataout(dout), .rd_valid(vld), .busy(busy), .err(err)
   );

   instmem_boot #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .BOOT_LEN(3)) dut16 (
      .clk(clk), .reset(rst2), .write(wr2), .addr(ad2), .datain(di2), .be(be2),
      .rd_req(rd2), .dataout(dout2), .rd_valid(vld2), .busy(busy2), .err(err2)
   );

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [31:0] m [256];
   logic [31:0] img [5] = '{32'h60400000, 32'h60400014, 32'h60800000,
                            32'h6080001A, 32'h08C22000};
   int          boot_rem = 5;
   logic [31:0] e_dout = '0;
   logic        e_vld = 1'b0, e_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply current inputs for one edge, advance the model, check every output.
   task automatic step(input string tag);
      if (rst) begin
         boot_rem = 5; e_dout = '0; e_vld = 1'b0; e_err = 1'b0;
      end else if (boot_rem > 0) begin
         m[5 - boot_rem] = img[5 - boot_rem];
         boot_rem--;
         e_vld = 1'b0; e_err = 1'b0;
      end else begin
         e_vld = rd;
         e_err = (rd || wr) && (ad >= 16'd256);
         if (rd) e_dout = (ad < 16'd256) ? m[ad[7:0]] : 32'h0;
         if (wr && ad < 16'd256)
            for (int i = 0; i < 4; i++)
               if (be[i]) m[ad[7:0]][8*i +: 8] = di[8*i +: 8];
      end
      @(posedge clk); @(negedge clk);
      chk({tag, "_dout"}, dout, e_dout);
      chk({tag, "_vld"},  {31'b0, vld},  {31'b0, e_vld});
      chk({tag, "_err"},  {31'b0, err},  {31'b0, e_err});
      chk({tag, "_busy"}, {31'b0, busy}, {31'b0, boot_rem > 0});
   endtask

   task automatic cyc();
      @(posedge clk); @(negedge clk);
   endtask

   logic [15:0] w3;

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; ad = '0; di = '0; be = '0;
      rst2 = 1'b1; wr2 = 1'b0; rd2 = 1'b0; ad2 = '0; di2 = '0; be2 = '0;

      // reset, then boot of exactly five edges
      step("rst"); step("rst");
      rst = 1'b0;
      repeat (5) step("boot");
      for (int a = 0; a < 5; a++) begin
         rd = 1'b1; ad = 16'(a);
         step("bootrd");
         chk("boot_img", dout, img[a]);
      end
      rd = 1'b0;

      // byte enables
      wr = 1'b1; ad = 16'd10; di = 32'h11223344; be = 4'hF; step("w10");
      di = 32'hDEADBEEF; be = 4'b0101; step("w10be");
      wr = 1'b0; rd = 1'b1; step("r10");
      chk("be_merge", dout, 32'h11AD33EF);
      rd = 1'b0; wr = 1'b1; di = 32'hFFFFFFFF; be = 4'h0; step("w10be0");
      wr = 1'b0; rd = 1'b1; step("r10b");
      chk("be_zero", dout, 32'h11AD33EF);

      // read-first on same-address read/write
      rd = 1'b0; wr = 1'b1; ad = 16'd7; di = 32'h7; be = 4'hF; step("w7");
      rd = 1'b1; di = 32'hCAFEF00D; step("rw7");
      chk("read_first", dout, 32'h00000007);
      wr = 1'b0; step("r7");
      chk("write_lands", dout, 32'hCAFEF00D);

      // out of range
      ad = 16'd300; step("oor_rd");
      chk("oor_rd_err", {31'b0, err}, 32'd1);
      rd = 1'b0; wr = 1'b1; ad = 16'd256; di = 32'h0; step("oor_wr");
      chk("oor_wr_err", {31'b0, err}, 32'd1);
      wr = 1'b0; rd = 1'b1; ad = 16'd0; step("r0");
      chk("oor_wr_nomod", dout, 32'h60400000);
      wr = 1'b1; ad = 16'd400; step("oor_rw");
      wr = 1'b0; rd = 1'b0; step("oor_after");
      chk("oor_single_pulse", {31'b0, err}, 32'd0);

      // reset while a read is in flight, then reset mid-boot with rd_req held
      rd = 1'b1; ad = 16'd1; step("pre_rst");
      rst = 1'b1; step("rst_mid_run");
      rst = 1'b0; ad = 16'd0; wr = 1'b1; di = 32'h55555555; be = 4'hF;
      ad = 16'd10;
      step("boot_drop"); step("boot_drop");
      wr = 1'b0;
      rst = 1'b1; step("rst_mid_boot");
      rst = 1'b0;
      repeat (5) step("reboot_hold");
      repeat (3) step("hold_rd");
      chk("busy_drop_write", dout, 32'h11AD33EF);

      // fill memory with known data, then random traffic
      rd = 1'b0; wr = 1'b1; be = 4'hF;
      for (int a = 5; a < 256; a++) begin
         ad = 16'(a); di = $urandom;
         step("fill");
      end
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         wr  = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         ad  = 16'($urandom_range(0, 299));
         di  = $urandom;
         be  = 4'($urandom_range(0, 15));
         step("rand");
      end
      rst = 1'b0; wr = 1'b0; rd = 1'b0;
      repeat (6) step("settle");

      // narrow configuration
      cyc(); cyc();
      chk("n_rst_busy", {31'b0, busy2}, 32'd1);
      chk("n_rst_dout", {16'b0, dout2}, 32'd0);
      chk("n_rst_vld",  {31'b0, vld2},  32'd0);
      rst2 = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         cyc();
         chk("n_boot_busy", {31'b0, busy2}, {31'b0, e < 3});
      end
      for (int k = 0; k < 3; k++) begin
         rd2 = 1'b1; ad2 = 16'(k); cyc();
         chk("n_boot_img", {16'b0, dout2}, (k == 1) ? 32'h14 : 32'h0);
         chk("n_boot_vld", {31'b0, vld2}, 32'd1);
      end
      w3 = 16'($urandom_range(1, 65535));
      rd2 = 1'b0; wr2 = 1'b1; be2 = 2'b11; ad2 = 16'd3; di2 = w3; cyc();
      ad2 = 16'd0; di2 = 16'h1234; cyc();
      wr2 = 1'b0; rst2 = 1'b1; cyc();
      rst2 = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         cyc();
         chk("n_reboot_busy", {31'b0, busy2}, {31'b0, e < 3});
      end
      rd2 = 1'b1; ad2 = 16'd3; cyc();
      chk("n_keep_w3", {16'b0, dout2}, {16'b0, w3});
      ad2 = 16'd0; cyc();
      chk("n_reboot_w0", {16'b0, dout2}, 32'h0);
      ad2 = 16'd64; cyc();
      chk("n_oor_dout", {16'b0, dout2}, 32'h0);
      chk("n_oor_err",  {31'b0, err2},  32'd1);
      chk("n_oor_vld",  {31'b0, vld2},  32'd1);
      rd2 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instmem_boot.md
# instmem_boot

Parametrised instruction memory for the CPU data path with a built-in boot loader. After reset a small FSM copies a fixed boot image into the low words. It then serves registered, handshaked instruction fetches and byte-enabled program writes. It replaces the fixed 256×32 combinational-read instruction memory and sits between the PC/fetch logic and the program loader.

## Interface
- DATA_W, 32, instruction word width; multiple of 8.
- ADDR_W, 16, address port width.
- DEPTH, 256, number of words; DEPTH ≤ 2^ADDR_W.
- BOOT_LEN, 5, boot-image words written after reset; 1..5, ≤ DEPTH.

- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write  in  1  write strobe; honoured only when busy=0.
- addr  in  ADDR_W  word address for both read and write.
- datain  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i gates datain[8i+7:8i].
- rd_req  in  1  fetch request; honoured only when busy=0.
- dataout  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: dataout holds the data for the last accepted rd_req.
- busy  out  1  high during reset and boot; fetches and writes are ignored.
- err  out  1  one-cycle pulse: an accepted read or write addressed ≥ DEPTH.

## Operation
- FSM states: BOOT, RUN.
- reset=1 forces BOOT, boot counter=0, dataout=0, rd_valid=0, err=0, busy=1.
- Memory contents are not cleared by reset.
- BOOT: each edge with reset=0 writes boot word[cnt] to mem[cnt] (full word, be ignored) and increments cnt.
- After the write of cnt=BOOT_LEN-1, the FSM goes to RUN and busy drops.
- Boot image, words 0..4: 0x60400000, 0x60400014, 0x60800000, 0x6080001A, 0x08C22000.
- Words BOOT_LEN..DEPTH-1 keep their prior contents.
- RUN, write=1 and addr<DEPTH: each byte lane with be[i]=1 is updated; lanes with be[i]=0 are unchanged.
- RUN, rd_req=1 and addr<DEPTH: dataout ← mem[addr]; rd_valid pulses the next cycle.
- RUN, rd_req and write to the same address in the same cycle: read-first; dataout returns the pre-write word, and the write still lands.
- Out of range (addr≥DEPTH) on an accepted read: dataout ← 0, rd_valid=1, err=1.
- Out of range on an accepted write: memory unchanged, err=1.
- Simultaneous out-of-range read and write: a single err pulse.
- rd_req and write while busy=1: dropped silently, no rd_valid, no err, no queueing.
- Reset asserted mid-boot or mid-RUN: returns to BOOT with cnt=0.
  - A read accepted in the cycle before reset produces no rd_valid.
  - Words already written stay written.
- dataout holds its value between reads; it changes only on an accepted read or on reset.

## Timing
- Reset values: dataout=0, rd_valid=0, err=0, busy=1.
- Boot duration: exactly BOOT_LEN edges after the first edge with reset=0.
- busy is 0 from the cycle after the edge that writes word BOOT_LEN-1.
- Read latency is 1 cycle: request sampled at edge N; dataout and rd_valid are valid after edge N and until edge N+1.
- Throughput is one read per cycle; back-to-back rd_req gives continuous rd_valid.
- A write is visible to a read issued at the following edge (write at N, read at N+1 returns the new data).
- err is aligned with rd_valid for reads, and occurs in the cycle after the write edge for writes.

## Test plan
- Reset 2 cycles then release: busy=1 for exactly 5 edges. Then read addr 0..4: 0x60400000, 0x60400014, 0x60800000, 0x6080001A, 0x08C22000, each rd_valid 1 cycle after its request.
- Write 0xDEADBEEF to addr 10 with be=4'b0101 over an old value of 0x11223344. Read back 0x11AD33EF; a following 0xFFFFFFFF write with be=0 leaves it unchanged.
- Same-cycle write 0xCAFEF00D (be=1111) and read at addr 7 holding 0x00000007: dataout=0x00000007. A next-cycle read returns 0xCAFEF00D.
- Read addr 300 with DEPTH=256: dataout=0, rd_valid=1, err=1. A write to addr 256 pulses err and leaves mem[0] unchanged.
- Assert reset 2 edges into boot, then release: busy stays high for 5 more edges. rd_req held throughout yields no rd_valid until busy=0, then a pulse every cycle.
- Rerun with DATA_W=16, DEPTH=64, BOOT_LEN=3: the boot takes 3 edges and word 3 keeps its pre-reset contents.
